// File: rtl/inject_port.sv
// Host-side collective injection stage: request FIFO, credit-gated flit issue, per-node sequence stamping.
// Optional macro INJECT_PARITY_EN enables even parity in flit bit [54] (otherwise bit [54] is tied to 0).
module inject_port #(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned CREDITS = 4,
  parameter logic [8:0]  NODE_ID = 9'd0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [3:0]              req_op,
  input  logic [7:0]              req_comm,
  input  logic [31:0]             req_payload,
  input  logic                    credit_ret,
  output logic [84:0]             in_xpos_inject,
  output logic [$clog2(DEPTH):0]  fifo_level,
  output logic [3:0]              credits,
  output logic                    credit_err
);

  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned LVL_W  = PTR_W + 1;
  localparam int unsigned FLIT_W = 85;

  typedef struct packed {
    logic [3:0]  op;
    logic [7:0]  comm;
    logic [31:0] payload;
  } req_t;

  typedef enum logic [1:0] {IDLE, SEND, STALL} state_e;

  req_t              mem [DEPTH];
  req_t              head;

  state_e            state_q, state_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic [3:0]        credits_q, credits_d;
  logic [7:0]        seq_q, seq_d;
  logic              err_q, err_d;
  logic [FLIT_W-1:0] flit_q, flit_d;

  logic push, pop, has_data, has_cred;

  // Issue decision is taken purely from registered level and credits.
  always_comb begin
    req_ready = (level_q != LVL_W'(DEPTH));
    has_data  = (level_q != '0);
    has_cred  = (credits_q != '0);
    push      = req_valid && req_ready;
    pop       = has_data && has_cred;
    head      = mem[rd_ptr_q];

    wr_ptr_d  = push ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
    rd_ptr_d  = pop  ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
    seq_d     = pop  ? (seq_q + 8'd1)         : seq_q;

    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase

    credits_d = credits_q;
    err_d     = err_q;
    if (pop && !credit_ret) begin
      credits_d = credits_q - 4'd1;
    end else if (credit_ret && !pop) begin
      if (credits_q == 4'(CREDITS)) begin
        err_d = 1'b1;
      end else begin
        credits_d = credits_q + 4'd1;
      end
    end

    if (pop) begin
      state_d = SEND;
    end else if (has_data) begin
      state_d = STALL;
    end else begin
      state_d = IDLE;
    end

    flit_d = flit_q;
    if (pop) begin
      flit_d         = '0;
      flit_d[84]     = 1'b1;
      flit_d[83:80]  = head.op;
      flit_d[79:72]  = head.comm;
      flit_d[71:63]  = NODE_ID;
      flit_d[62:55]  = seq_q;
      flit_d[31:0]   = head.payload;
`ifdef INJECT_PARITY_EN
      flit_d[54]     = ^{flit_d[83:55], flit_d[53:0]};
`else
      flit_d[54]     = 1'b0;
`endif
    end
  end

  // Storage needs no reset: occupancy is defined by the pointers and level.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= '{op: req_op, comm: req_comm, payload: req_payload};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      credits_q <= 4'(CREDITS);
      seq_q     <= '0;
      err_q     <= 1'b0;
      flit_q    <= '0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      credits_q <= credits_d;
      seq_q     <= seq_d;
      err_q     <= err_d;
      flit_q    <= flit_d;
    end
  end

  // Flit register only loads on a pop; SEND marks the single cycle it is presented.
  assign in_xpos_inject = (state_q == SEND) ? flit_q : '0;
  assign fifo_level     = level_q;
  assign credits        = credits_q;
  assign credit_err     = err_q;

endmodule
